// File: rtl/d_phy_transmitter.sv
// HS-only D-PHY data-lane transmitter: one HS burst per packet (HS-zero, sync 0xB8, payload, trail)
// emitted as 2 bits per clock_p cycle, with clock-lane gating around the burst.
module d_phy_transmitter #(
   parameter int unsigned CLK_PRE_CYCLES  = 8,
   parameter int unsigned HS_ZERO_CYCLES  = 6,
   parameter int unsigned TRAIL_CYCLES    = 4,
   parameter int unsigned CLK_POST_CYCLES = 16
) (
   input  logic       clock_p,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       in_ready,
   output logic [1:0] dout,
   output logic       hs_active,
   output logic       clock_active,
   output logic       busy,
   output logic       underflow
);

   typedef enum logic [2:0] {
      StIdle, StClkPre, StHsZero, StSync, StData, StTrail, StClkPost
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] ph_q, ph_d;
   logic [7:0] sr_q, sr_d;
   logic       last_flag_q, last_flag_d;
   logic       last_bit_q, last_bit_d;
   logic       hs_active_q, hs_active_d;
   logic       clock_active_q, clock_active_d;
   logic       busy_q, busy_d;
   logic       underflow_q, underflow_d;
   logic       load_cyc;

   // A byte is fetched on the last phase of sync, and of every payload byte not flagged last.
   assign load_cyc = (ph_q == 2'd3) &&
                     ((state_q == StSync) || ((state_q == StData) && !last_flag_q));
   assign in_ready = load_cyc;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      ph_d           = ph_q;
      sr_d           = sr_q;
      last_flag_d    = last_flag_q;
      last_bit_d     = last_bit_q;
      hs_active_d    = hs_active_q;
      clock_active_d = clock_active_q;
      busy_d         = busy_q;
      underflow_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d        = StClkPre;
               cnt_d          = 8'(CLK_PRE_CYCLES - 1);
               clock_active_d = 1'b1;
               busy_d         = 1'b1;
            end
         end
         StClkPre: begin
            if (cnt_q == 8'd0) begin
               state_d     = StHsZero;
               cnt_d       = 8'(HS_ZERO_CYCLES - 1);
               hs_active_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StHsZero: begin
            if (cnt_q == 8'd0) begin
               state_d    = StSync;
               sr_d       = 8'hB8;
               ph_d       = 2'd0;
               last_bit_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StSync, StData: begin
            sr_d = {2'b00, sr_q[7:2]};
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd3) begin
               if (load_cyc && in_valid) begin
                  state_d     = StData;
                  sr_d        = in_data;
                  last_flag_d = in_last;
                  last_bit_d  = in_data[7];
               end else begin
                  // Either the flagged last byte is done or upstream starved us.
                  underflow_d = load_cyc;
                  state_d     = StTrail;
                  cnt_d       = 8'(TRAIL_CYCLES - 1);
                  sr_d        = {8{~last_bit_q}};
               end
            end
         end
         StTrail: begin
            if (cnt_q == 8'd0) begin
               state_d     = StClkPost;
               cnt_d       = 8'(CLK_POST_CYCLES - 1);
               hs_active_d = 1'b0;
               sr_d        = 8'h00;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StClkPost: begin
            if (cnt_q == 8'd0) begin
               state_d        = StIdle;
               ph_d           = 2'd0;
               last_flag_d    = 1'b0;
               last_bit_d     = 1'b0;
               clock_active_d = 1'b0;
               busy_d         = 1'b0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d        = StIdle;
            cnt_d          = 8'd0;
            ph_d           = 2'd0;
            sr_d           = 8'h00;
            hs_active_d    = 1'b0;
            clock_active_d = 1'b0;
            busy_d         = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock_p) begin
      if (reset) begin
         state_q        <= StIdle;
         cnt_q          <= 8'd0;
         ph_q           <= 2'd0;
         sr_q           <= 8'h00;
         last_flag_q    <= 1'b0;
         last_bit_q     <= 1'b0;
         hs_active_q    <= 1'b0;
         clock_active_q <= 1'b0;
         busy_q         <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ph_q           <= ph_d;
         sr_q           <= sr_d;
         last_flag_q    <= last_flag_d;
         last_bit_q     <= last_bit_d;
         hs_active_q    <= hs_active_d;
         clock_active_q <= clock_active_d;
         busy_q         <= busy_d;
         underflow_q    <= underflow_d;
      end
   end

   assign dout         = sr_q[1:0];
   assign hs_active    = hs_active_q;
   assign clock_active = clock_active_q;
   assign busy         = busy_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_d_phy_transmitter.sv
// Bench for d_phy_transmitter: per-cycle burst model built from packet contents, plus a DDR
// bit-stream receiver that re-finds the sync byte and recovers the payload.
module tb_d_phy_transmitter;

   localparam int unsigned Pre   = 8;
   localparam int unsigned HsZ   = 6;
   localparam int unsigned Trail = 4;
   localparam int unsigned Post  = 16;

   logic       clock_p  = 1'b0;
   logic       reset    = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_last  = 1'b0;
   logic       in_ready;
   logic [1:0] dout;
   logic       hs_active, clock_active, busy, underflow;

   d_phy_transmitter #(
      .CLK_PRE_CYCLES (Pre),
      .HS_ZERO_CYCLES (HsZ),
      .TRAIL_CYCLES   (Trail),
      .CLK_POST_CYCLES(Post)
   ) dut (
      .clock_p     (clock_p),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .dout        (dout),
      .hs_active   (hs_active),
      .clock_active(clock_active),
      .busy        (busy),
      .underflow   (underflow)
   );

   always #5 clock_p = ~clock_p;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0]  pkt [64];
   int          n_bytes;
   int          n_send;
   logic [6:0]  exp_q [$];
   bit          bit_q [$];

   function automatic logic [6:0] vec(input bit uf, input bit rdy, input bit bsy, input bit ck,
                                      input bit hs, input logic [1:0] d);
      return {uf, rdy, bsy, ck, hs, d};
   endfunction

   // Expected {underflow,in_ready,busy,clock_active,hs_active,dout} for every cycle of one burst.
   task automatic build_model();
      logic [7:0] sb;
      logic [7:0] b;
      bit         tbit;
      bit         uf;
      exp_q.delete();
      sb   = 8'hB8;
      tbit = 1'b0;
      uf   = (n_send < n_bytes);
      repeat (Pre) exp_q.push_back(vec(0, 0, 1, 1, 0, 2'b00));
      repeat (HsZ) exp_q.push_back(vec(0, 0, 1, 1, 1, 2'b00));
      for (int p = 0; p < 4; p++) exp_q.push_back(vec(0, p == 3, 1, 1, 1, sb[2*p +: 2]));
      for (int j = 0; j < n_send; j++) begin
         b = pkt[j];
         for (int p = 0; p < 4; p++)
            exp_q.push_back(vec(0, (p == 3) && (j < n_bytes - 1), 1, 1, 1, b[2*p +: 2]));
         tbit = ~b[7];
      end
      for (int t = 0; t < Trail; t++) exp_q.push_back(vec(uf && (t == 0), 0, 1, 1, 1, {tbit, tbit}));
      repeat (Post) exp_q.push_back(vec(0, 0, 1, 1, 0, 2'b00));
      exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00));
   endtask

   function automatic logic [6:0] observed();
      return {underflow, in_ready, busy, clock_active, hs_active, dout};
   endfunction

   // Drives one packet and checks every cycle; abort_at >= 0 stops early before that cycle.
   task automatic run_packet(input bit keep_valid, input int abort_at);
      int   idx;
      int   handshakes;
      bit   pend;
      int   start;
      bit   found;
      logic [7:0] rx;
      build_model();
      bit_q.delete();
      idx        = 0;
      handshakes = 0;
      pend       = 1'b0;
      @(negedge clock_p);
      in_valid = 1'b1;
      in_data  = pkt[0];
      in_last  = (n_bytes == 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == abort_at) return;
         @(posedge clock_p);
         #1;
         if (pend) begin
            handshakes++;
            idx++;
            if (idx >= n_send) begin
               in_valid = keep_valid;
            end else begin
               in_data = pkt[idx];
               in_last = (idx == n_bytes - 1);
            end
         end
         check_eq($sformatf("cyc%0d", i), observed(), exp_q[i]);
         if (hs_active) begin
            bit_q.push_back(dout[0]);
            bit_q.push_back(dout[1]);
         end
         pend = in_valid && in_ready;
      end
      check_eq("handshakes", handshakes, n_send);
      found = 1'b0;
      start = 0;
      for (int s = 0; s + 8 <= bit_q.size() && !found; s++) begin
         for (int k = 0; k < 8; k++) rx[k] = bit_q[s+k];
         if (rx == 8'hB8) begin
            found = 1'b1;
            start = s + 8;
         end
      end
      check_eq("rx_sync_found", found, 1'b1);
      for (int j = 0; j < n_send; j++) begin
         rx = 8'h00;
         for (int k = 0; k < 8; k++)
            if (start + 8*j + k < bit_q.size()) rx[k] = bit_q[start + 8*j + k];
         check_eq($sformatf("rx_byte%0d", j), rx, pkt[j]);
      end
   endtask

   task automatic rand_packet(input int n);
      n_bytes = n;
      n_send  = n;
      for (int j = 0; j < n; j++) pkt[j] = 8'($urandom);
   endtask

   initial begin
      repeat (3) @(posedge clock_p);
      #1;
      check_eq("reset_outs", observed(), 7'd0);
      @(negedge clock_p);
      reset = 1'b0;

      // Single byte 0x5A: trail is 11 since bit7 is 0.
      n_bytes = 1; n_send = 1; pkt[0] = 8'h5A;
      run_packet(1'b0, -1);

      n_bytes = 3; n_send = 3; pkt[0] = 8'h01; pkt[1] = 8'h80; pkt[2] = 8'hFF;
      run_packet(1'b0, -1);

      // Starve after the first byte of a 4-byte packet.
      rand_packet(4);
      n_send = 1;
      run_packet(1'b0, -1);

      // Reset during payload, then a clean packet.
      rand_packet(4);
      run_packet(1'b0, int'($urandom_range(19, 34)));
      @(negedge clock_p);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clock_p);
      #1;
      check_eq("mid_reset_outs", observed(), 7'd0);
      @(negedge clock_p);
      reset = 1'b0;
      rand_packet(5);
      run_packet(1'b0, -1);

      for (int r = 0; r < 12; r++) begin
         rand_packet(int'($urandom_range(1, 64)));
         run_packet(1'b0, -1);
      end

      // Back-to-back with in_valid held high across the IDLE cycle.
      rand_packet(3);
      run_packet(1'b1, -1);
      rand_packet(2);
      run_packet(1'b0, -1);

      for (int r = 0; r < 4; r++) begin
         rand_packet(int'($urandom_range(2, 16)));
         n_send = int'($urandom_range(1, n_bytes - 1));
         run_packet(1'b0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
